// File: rtl/out_port_uart_pkg.sv
// Shared types and constants for the OUT-port UART bridge.
// Also holds the bit-select helper used by the serializer.
package out_port_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic        UART_IDLE  = 1'b1;
    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned WORD_BITS  = 16;

    // Bit of the word currently on the line: hi_byte selects the byte, idx the bit (LSB first).
    function automatic logic word_bit(input logic [WORD_BITS-1:0] word,
                                      input logic                 hi_byte,
                                      input logic [2:0]           idx);
        logic [3:0] sel;
        sel = {hi_byte, idx};
        return word[sel];
    endfunction

endpackage

// File: rtl/out_port_uart_sync_fifo.sv
// Synchronous single-clock FIFO with registered full/empty/level.
// Kept generic so a future IN-port receive path can reuse it.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so plain increment wraps modulo DEPTH.
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            full  <= (level_next == LW'(DEPTH));
            empty <= (level_next == '0);
        end
    end

endmodule

// File: rtl/out_port_uart.sv
// Serial output bridge: buffers CPU OUT words and sends each as two 8N1 frames,
// low byte first. A full FIFO drops the word and raises sticky overflow.
module out_port_uart
    import out_port_uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       out_we,
    input  logic [15:0]                out_data,
    input  logic                       ovf_clr,
    output logic                       tx,
    output logic                       busy,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    tx_state_t      state;
    tx_state_t      state_next;
    logic [BW-1:0]  baud_cnt;
    logic [BW-1:0]  baud_next;
    logic [2:0]     bit_idx;
    logic [2:0]     bit_next;
    logic           hi_byte;
    logic           hi_next;
    logic [15:0]    word;
    logic [15:0]    word_next;
    logic           tx_next;
    logic           baud_last;
    logic           push;
    logic           pop;
    logic [15:0]    fifo_dout;

    assign push      = out_we && !full;
    assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign busy      = (state != IDLE);

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (out_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BW'(1);
        bit_next   = bit_idx;
        hi_next    = hi_byte;
        word_next  = word;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                baud_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    word_next  = fifo_dout;
                    hi_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (!hi_byte) begin
                        hi_next    = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

        // Line level is derived from the next state so the registered tx lines up with it.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = word_bit(word_next, hi_next, bit_next);
            default: tx_next = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            hi_byte  <= 1'b0;
            word     <= '0;
            tx       <= UART_IDLE;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            hi_byte  <= hi_next;
            word     <= word_next;
            tx       <= tx_next;
            if (out_we && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_out_port_uart.sv
// Self-checking bench for out_port_uart: directed vector table, multi-cycle corner
// sequences and random traffic, all compared against a word-level queue model.
module tb_out_port_uart;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned LW    = $clog2(DEPTH+1);
    localparam int          WORD_CYC = 20 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          out_we;
    logic [15:0]   out_data;
    logic          ovf_clr;
    logic          tx;
    logic          busy;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic          overflow;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Word-level reference: queue of pending words plus remaining line time of the word in flight.
    logic [15:0] mq[$];
    int          ser_left = 0;
    logic [15:0] cur = '0;
    bit          m_ovf = 1'b0;

    always #5 clk = ~clk;

    out_port_uart #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_we   (out_we),
        .out_data (out_data),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        bit m_full;
        bit m_empty;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq.delete();
                ser_left = 0;
                m_ovf    = 1'b0;
            end else begin
                m_full  = (mq.size() == DEPTH);
                m_empty = (mq.size() == 0);
                if (ser_left > 0) begin
                    ser_left--;
                end else if (!m_empty) begin
                    cur      = mq.pop_front();
                    ser_left = WORD_CYC;
                end
                if (out_we && m_full) m_ovf = 1'b1;
                else if (ovf_clr)     m_ovf = 1'b0;
                if (out_we && !m_full) mq.push_back(out_data);
            end
        end
    end

    initial begin
        int   p;
        int   s;
        logic e_tx;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (ser_left == 0) begin
                    e_tx = 1'b1;
                end else begin
                    p = WORD_CYC - ser_left;
                    s = p / N;
                    if (s == 0 || s == 10)       e_tx = 1'b0;
                    else if (s == 9 || s == 19)  e_tx = 1'b1;
                    else if (s < 9)              e_tx = cur[s-1];
                    else                         e_tx = cur[s-3];
                end
                check("tx",       {31'd0, tx},       {31'd0, e_tx});
                check("busy",     {31'd0, busy},     {31'd0, ser_left != 0});
                check("empty",    {31'd0, empty},    {31'd0, mq.size() == 0});
                check("full",     {31'd0, full},     {31'd0, mq.size() == DEPTH});
                check("level",    32'(level),        32'(mq.size()));
                check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!(mq.size() == 0 && ser_left == 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait_bound", n < 3000, 1);
    endtask

    task automatic wait_tx_low(output int at);
        int n = 0;
        while (tx !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("start_wait_bound", n < 500, 1);
        at = cyc;
    endtask

    task automatic send_and_decode(input logic [15:0] w, output logic [7:0] lo,
                                   output logic [7:0] hi, output logic [3:0] framing,
                                   output int busy_cycles);
        logic slots [20];
        busy_cycles = 0;
        out_we = 1'b1; out_data = w;
        @(negedge clk);
        out_we = 1'b0;
        check("latency_tx_still_idle", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("latency_tx_start", {31'd0, tx}, 32'd0);
        for (int i = 0; i < WORD_CYC; i++) begin
            if (i % N == N / 2) slots[i / N] = tx;
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) begin
            lo[k] = slots[1 + k];
            hi[k] = slots[11 + k];
        end
        framing = {slots[19], slots[10], slots[9], slots[0]};
        check("end_busy",  {31'd0, busy},  32'd0);
        check("end_empty", {31'd0, empty}, 32'd1);
        check("end_tx",    {31'd0, tx},    32'd1);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [3:0]  framing;
        int          bc;
        int          t0;
        int          t1;
        int          peak;
        int          lows;
        int          n;
        bit          saw_full;

        vecs[0] = '{16'hA55A, 8'h5A, 8'hA5};
        vecs[1] = '{16'h0001, 8'h01, 8'h00};
        vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[3] = '{16'h1234, 8'h34, 8'h12};
        vecs[4] = '{16'h8000, 8'h00, 8'h80};

        rst = 1'b1; out_we = 1'b0; out_data = '0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx",       {31'd0, tx},       32'd1);
        check("reset_busy",     {31'd0, busy},     32'd0);
        check("reset_empty",    {31'd0, empty},    32'd1);
        check("reset_full",     {31'd0, full},     32'd0);
        check("reset_level",    32'(level),        32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed single words, decoded straight off the line.
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            send_and_decode(vecs[v].word, lo, hi, framing, bc);
            check("vec_lo_byte", 32'(lo), 32'(vecs[v].lo));
            check("vec_hi_byte", 32'(hi), 32'(vecs[v].hi));
            check("vec_framing", 32'(framing), 32'b1010);
            check("vec_busy_cycles", bc, WORD_CYC);
        end

        // Burst of 10 writes: one in flight, eight queued, tenth dropped.
        wait_idle();
        peak = 0; saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            out_we = 1'b1; out_data = 16'(32'hC000 + i);
            @(negedge clk);
            if (int'(level) > peak) peak = int'(level);
            if (full) saw_full = 1'b1;
        end
        out_we = 1'b0;
        check("burst_peak_level", peak, DEPTH);
        check("burst_saw_full",   {31'd0, saw_full}, 32'd1);
        check("burst_overflow",   {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr_clears", {31'd0, overflow}, 32'd0);

        // Dropped write and clear in the same cycle: set wins.
        out_we = 1'b1; out_data = 16'hDEAD; ovf_clr = 1'b1;
        @(negedge clk);
        out_we = 1'b0; ovf_clr = 1'b0;
        check("set_beats_clr", {31'd0, overflow}, 32'd1);
        check("still_full",    {31'd0, full},     32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_clr_again", {31'd0, overflow}, 32'd0);

        // Back-to-back words: second start bit one word plus one idle cycle later.
        wait_idle();
        out_we = 1'b1; out_data = 16'h0001;
        @(negedge clk);
        out_data = 16'hFFFF;
        @(negedge clk);
        out_we = 1'b0;
        wait_tx_low(t0);
        repeat (WORD_CYC) @(negedge clk);
        wait_tx_low(t1);
        check("b2b_start_spacing", t1 - t0, WORD_CYC + 1);

        // Reset 30 cycles into a word with three more queued.
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            out_we = 1'b1; out_data = 16'($urandom);
            @(negedge clk);
        end
        out_we = 1'b0;
        wait_tx_low(t0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx",    {31'd0, tx},    32'd1);
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_empty", {31'd0, empty}, 32'd1);
        check("abort_level", 32'(level),     32'd0);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("abort_line_quiet", lows, 0);

        // Push and pop in the same cycle at level 3.
        for (int i = 0; i < 4; i++) begin
            out_we = 1'b1; out_data = 16'($urandom);
            @(negedge clk);
        end
        out_we = 1'b0;
        check("pp_level_before", 32'(level), 32'd3);
        n = 0;
        while (ser_left != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pp_idle_wait_bound", n < 200, 1);
        out_we = 1'b1; out_data = 16'h5A5A;
        @(negedge clk);
        out_we = 1'b0;
        check("pp_level_same", 32'(level), 32'd3);
        check("pp_busy",       {31'd0, busy}, 32'd1);

        // Fill/drain 20 words across pointer wrap; order checked on the line each cycle.
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (mq.size() >= DEPTH && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("fill_wait_bound", n < 1000, 1);
            out_we = 1'b1; out_data = 16'($urandom);
            @(negedge clk);
            out_we = 1'b0;
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle();

        // Random traffic including overflow and clears.
        for (int i = 0; i < 1500; i++) begin
            out_we   = ($urandom_range(0, 15) == 0);
            out_data = 16'($urandom);
            ovf_clr  = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        out_we = 1'b0; ovf_clr = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
